// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Resolves load-use hazards, taken-branch flushes, multi-cycle divide
// occupancy of EX and data-memory wait states.
// Optional feature: define PIPE_STALL_CNT_EN to build the 32-bit saturating
// stall-cycle counter; otherwise o_stall_cycles is tied to zero.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_div_start,
  input  logic                  i_id_branch_taken,
  input  logic                  i_mem_req,
  input  logic                  i_mem_ready,
  output logic                  o_pc_en,
  output logic                  o_ifid_en,
  output logic                  o_idex_en,
  output logic                  o_exmem_en,
  output logic                  o_memwb_en,
  output logic                  o_ifid_clr,
  output logic                  o_idex_clr,
  output logic                  o_exmem_clr,
  output logic                  o_memwb_clr,
  output logic                  o_div_busy,
  output logic                  o_div_done,
  output logic [31:0]           o_stall_cycles
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_CYCLES - 2);

  typedef enum logic {ST_RUN, ST_DIV} state_t;
  typedef enum logic [2:0] {
    M_NORMAL, M_FLUSH, M_LOADUSE, M_DIVSTALL, M_MEMSTALL, M_RESET
  } mode_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mem_stall;
  logic             w_load_use;
  mode_t            w_mode;

  assign w_mem_stall = i_mem_req & ~i_mem_ready;
  assign w_load_use  = i_ex_mem_read & (i_ex_rt != '0) &
                       ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));

  // Pick the pipeline response for this cycle from state, count and hazards.
  always_comb begin
    w_mode     = M_NORMAL;
    o_div_done = 1'b0;
    if (i_rst) begin
      w_mode = M_RESET;
    end else if (r_state == ST_DIV) begin
      if (w_mem_stall) begin
        w_mode = M_MEMSTALL;
      end else if (r_cnt != '0) begin
        w_mode = M_DIVSTALL;
      end else begin
        w_mode     = M_NORMAL;
        o_div_done = 1'b1;
      end
    end else begin
      if (w_mem_stall)            w_mode = M_MEMSTALL;
      else if (i_ex_div_start)    w_mode = M_DIVSTALL;
      else if (w_load_use)        w_mode = M_LOADUSE;
      else if (i_id_branch_taken) w_mode = M_FLUSH;
      else                        w_mode = M_NORMAL;
    end
  end

  assign o_div_busy = (r_state == ST_DIV) & ~i_rst;

  // Translate the chosen mode into register enables and clears.
  always_comb begin
    o_pc_en     = 1'b0;
    o_ifid_en   = 1'b0;
    o_idex_en   = 1'b0;
    o_exmem_en  = 1'b0;
    o_memwb_en  = 1'b0;
    o_ifid_clr  = 1'b0;
    o_idex_clr  = 1'b0;
    o_exmem_clr = 1'b0;
    o_memwb_clr = 1'b0;
    case (w_mode)
      M_NORMAL: begin
        o_pc_en    = 1'b1;
        o_ifid_en  = 1'b1;
        o_idex_en  = 1'b1;
        o_exmem_en = 1'b1;
        o_memwb_en = 1'b1;
      end
      M_FLUSH: begin
        o_pc_en    = 1'b1;
        o_ifid_en  = 1'b1;
        o_idex_en  = 1'b1;
        o_exmem_en = 1'b1;
        o_memwb_en = 1'b1;
        o_ifid_clr = 1'b1;
      end
      M_LOADUSE: begin
        o_exmem_en = 1'b1;
        o_memwb_en = 1'b1;
        o_idex_clr = 1'b1;
      end
      M_DIVSTALL: begin
        o_memwb_en  = 1'b1;
        o_exmem_clr = 1'b1;
      end
      M_MEMSTALL: begin
        o_memwb_clr = 1'b1;
      end
      default: begin
        o_ifid_clr  = 1'b1;
        o_idex_clr  = 1'b1;
        o_exmem_clr = 1'b1;
        o_memwb_clr = 1'b1;
      end
    endcase
  end

  // Divide occupancy tracking; memory stalls still let the divider progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      if (!w_mem_stall && i_ex_div_start) begin
        r_state <= ST_DIV;
        r_cnt   <= CNT_START;
      end
    end else begin
      if (w_mem_stall) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_state <= ST_RUN;
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  // Count non-reset cycles in which the PC was held, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
    end else if (!o_pc_en && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl with DIV_CYCLES=4: directed scenarios with
// literal expectations, then randomized traffic checked against a model.
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;
  localparam int DC = 4;
`ifdef PIPE_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // Mode vectors: {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb clears}
  localparam logic [8:0] V_NORMAL   = 9'b11111_0000;
  localparam logic [8:0] V_FLUSH    = 9'b11111_1000;
  localparam logic [8:0] V_LOADUSE  = 9'b00011_0100;
  localparam logic [8:0] V_DIVSTALL = 9'b00001_0010;
  localparam logic [8:0] V_MEMSTALL = 9'b00000_0001;
  localparam logic [8:0] V_RESET    = 9'b00000_1111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RW-1:0] idRs = '0, idRt = '0, exRt = '0;
  logic exMemRead = 1'b0, exDivStart = 1'b0, idBranchTaken = 1'b0;
  logic memReq = 1'b0, memReady = 1'b0;
  logic pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic ifidClr, idexClr, exmemClr, memwbClr, divBusy, divDone;
  logic [31:0] stallCycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .DIV_CYCLES(DC)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_rs(idRs), .i_id_rt(idRt), .i_ex_rt(exRt),
    .i_ex_mem_read(exMemRead), .i_ex_div_start(exDivStart),
    .i_id_branch_taken(idBranchTaken), .i_mem_req(memReq), .i_mem_ready(memReady),
    .o_pc_en(pcEn), .o_ifid_en(ifidEn), .o_idex_en(idexEn), .o_exmem_en(exmemEn),
    .o_memwb_en(memwbEn), .o_ifid_clr(ifidClr), .o_idex_clr(idexClr),
    .o_exmem_clr(exmemClr), .o_memwb_clr(memwbClr), .o_div_busy(divBusy),
    .o_div_done(divDone), .o_stall_cycles(stallCycles)
  );

  wire logic [8:0] actVec = {pcEn, ifidEn, idexEn, exmemEn, memwbEn,
                             ifidClr, idexClr, exmemClr, memwbClr};

  int nChecks = 0;
  int nFails  = 0;
  bit modelOn = 1'b0;

  // Reference model: whether a divide holds EX and how many DIV cycles remain
  // including the release cycle; memory stalls consume cycles but never the last.
  bit      mDiv   = 1'b0;
  int      mLeft  = 0;
  longint  mStall = 0;

  function automatic logic [10:0] modelOut();
    logic ms, lu;
    ms = memReq && !memReady;
    lu = exMemRead && (exRt != 0) && (exRt == idRs || exRt == idRt);
    if (rst)       return {2'b00, V_RESET};
    if (mDiv) begin
      if (ms)        return {2'b10, V_MEMSTALL};
      if (mLeft > 1) return {2'b10, V_DIVSTALL};
      return {2'b11, V_NORMAL};
    end
    if (ms)            return {2'b00, V_MEMSTALL};
    if (exDivStart)    return {2'b00, V_DIVSTALL};
    if (lu)            return {2'b00, V_LOADUSE};
    if (idBranchTaken) return {2'b00, V_FLUSH};
    return {2'b00, V_NORMAL};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on each edge using the inputs that were stable during the cycle.
  always @(posedge clk) begin
    logic [10:0] o;
    o = modelOut();
    if (rst) begin
      mDiv = 1'b0; mLeft = 0; mStall = 0;
    end else begin
      if (!o[8] && mStall < 64'hFFFF_FFFF) mStall++;
      if (mDiv) begin
        if (memReq && !memReady) mLeft = (mLeft > 1) ? mLeft - 1 : 1;
        else if (mLeft > 1)      mLeft--;
        else                     mDiv = 1'b0;
      end else if (!(memReq && !memReady) && exDivStart) begin
        mDiv = 1'b1; mLeft = DC - 1;
      end
    end
    modelOn = 1'b1;
  end

  // Every cycle compare all outputs against the model mid-cycle.
  always @(negedge clk) begin
    logic [10:0] o;
    if (modelOn) begin
      o = modelOut();
      checkOutput("model_outputs", {21'd0, divBusy, divDone, actVec}, {21'd0, o});
      checkOutput("model_stall_cycles", stallCycles, CNT_ON ? mStall[31:0] : 32'd0);
    end
  end

  task automatic applyStimulus(input logic r, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                               input logic [RW-1:0] ert, input logic mr, input logic ds,
                               input logic br, input logic rq, input logic rd);
    @(posedge clk);
    #1;
    rst = r; idRs = rs; idRt = rt; exRt = ert; exMemRead = mr;
    exDivStart = ds; idBranchTaken = br; memReq = rq; memReady = rd;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [8:0] divPc;
    logic [3:0] divBusyExp, divDoneExp;
    divPc = 9'b0;
    divBusyExp = 4'b1110;
    divDoneExp = 4'b1000;

    $display("[TB] start, stall counter %s", CNT_ON ? "built" : "absent");
    // Reset held for two cycles.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_vec_1", {23'd0, actVec}, {23'd0, V_RESET});
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_vec_2", {23'd0, actVec}, {23'd0, V_RESET});
    checkOutput("reset_busy", {31'd0, divBusy}, 32'd0);
    idle();
    checkOutput("after_reset_vec", {23'd0, actVec}, {23'd0, V_NORMAL});
    checkOutput("after_reset_stall", stallCycles, 32'd0);

    // Load-use hit, then a load to r0 which must not stall.
    applyStimulus(0, 5, 0, 5, 1, 0, 0, 0, 0);
    checkOutput("loaduse_vec", {23'd0, actVec}, {23'd0, V_LOADUSE});
    idle();
    checkOutput("loaduse_stall_cnt", stallCycles, CNT_ON ? 32'd1 : 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("load_r0_vec", {23'd0, actVec}, {23'd0, V_NORMAL});

    // Branch alone flushes; together with load-use the flush is suppressed.
    applyStimulus(0, 1, 2, 3, 0, 0, 1, 0, 0);
    checkOutput("branch_vec", {23'd0, actVec}, {23'd0, V_FLUSH});
    applyStimulus(0, 1, 7, 7, 1, 0, 1, 0, 0);
    checkOutput("branch_loaduse_vec", {23'd0, actVec}, {23'd0, V_LOADUSE});

    // Divide pulse: PC held three cycles, busy three cycles, done on the third.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      divPc[i] = pcEn;
      checkOutput($sformatf("div_busy_%0d", i), {31'd0, divBusy}, {31'd0, divBusyExp[i]});
      checkOutput($sformatf("div_done_%0d", i), {31'd0, divDone}, {31'd0, divDoneExp[i]});
      checkOutput($sformatf("div_exmem_clr_%0d", i), {31'd0, exmemClr}, {31'd0, (i < 3)});
      if (i < 3) idle();
    end
    checkOutput("div_pc_pattern", {28'd0, divPc[3:0]}, 32'h8);
    checkOutput("div_stall_cnt", stallCycles, CNT_ON ? 32'd5 : 32'd0);

    // Memory stall during a divide.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("memdiv_start_vec", {23'd0, actVec}, {23'd0, V_DIVSTALL});
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput($sformatf("memdiv_stall_%0d", i), {23'd0, actVec}, {23'd0, V_MEMSTALL});
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("memdiv_release_vec", {23'd0, actVec}, {23'd0, V_NORMAL});
    checkOutput("memdiv_release_done", {31'd0, divDone}, 32'd1);
    checkOutput("memdiv_stall_cnt", stallCycles, CNT_ON ? 32'd6 : 32'd0);

    // Reset while the divide count is at 1.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("middiv_reset_vec", {23'd0, actVec}, {23'd0, V_RESET});
    checkOutput("middiv_reset_done", {31'd0, divDone}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput($sformatf("middiv_after_vec_%0d", i), {23'd0, actVec}, {23'd0, V_NORMAL});
      checkOutput($sformatf("middiv_after_done_%0d", i), {30'd0, divBusy, divDone}, 32'd0);
    end
    checkOutput("middiv_stall_cnt", stallCycles, 32'd0);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                    RW'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
    end

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
